memory_sequence_controller: RTL
===============================

# memory_sequence_controller

Sequencing controller for the 16x4 synchronous sequence RAM of the memory-challenge game. It owns the RAM address, write-enable and write-data lines. Each round it plays the stored sequence on the LEDs, checks the player's inputs against RAM, and appends one new player-chosen item. It sits between the button/LED front panel and the RAM, and reports win/lose to the top level.

## Interface
Parameters:
- SHOW_CYCLES, 1000: clock cycles each sequence item is lit during playback (≥2).
- GAP_CYCLES, 250: clock cycles LEDs are dark between items (≥1).
- LAST_ROUND, 15: final round index (0..15); completing it wins.

Ports:
- clk  in  1: single clock, all logic on rising edge.
- reset  in  1: synchronous, active-high; dominates every other input.
- iniciar  in  1: start pulse; honoured only in IDLE, WIN, LOSE.
- jogada_valida  in  1: one-cycle pulse, player input present.
- jogada  in  4: player value, sampled on jogada_valida.
- ram_q  in  4: RAM read data; valid the cycle after ram_addr was stable at an edge.
- ram_addr  out  4: RAM address, registered.
- ram_we  out  1: RAM write enable, registered.
- ram_data  out  4: RAM write data, registered.
- leds  out  4: playback display.
- mostrando  out  1: high during playback (SHOW_ADDR, SHOW_ON, SHOW_GAP).
- rodada  out  4: current round index.
- acertou  out  1: high in WIN.
- errou  out  1: high in LOSE.
- db_estado  out  4: state encoding for debug.

## Operation
- States and db_estado encodings: IDLE 0, INIT 1, SHOW_ADDR 2, SHOW_ON 3, SHOW_GAP 4, PLAY_WAIT 5, PLAY_READ 6, PLAY_CMP 7, NEW_WAIT 8, NEW_WRITE 9, NEXT_ROUND A, WIN B, LOSE C.
- IDLE: iniciar → INIT.
- INIT: rodada=0, index i=0 → SHOW_ADDR.
- SHOW_ADDR: ram_addr=i; one cycle → SHOW_ON.
- SHOW_ON: leds=ram_q for SHOW_CYCLES cycles → SHOW_GAP.
- SHOW_GAP: leds=0 for GAP_CYCLES cycles. Then:
  - if i<rodada: i++ → SHOW_ADDR;
  - else: i=0 → PLAY_WAIT.
- PLAY_WAIT: on jogada_valida, capture jogada and set ram_addr=i → PLAY_READ.
- PLAY_READ: one cycle → PLAY_CMP.
- PLAY_CMP: if captured≠ram_q → LOSE. Otherwise:
  - if i<rodada: i++ → PLAY_WAIT;
  - else if rodada==LAST_ROUND → WIN;
  - else → NEW_WAIT.
- NEW_WAIT: on jogada_valida, capture jogada → NEW_WRITE.
- NEW_WRITE: ram_addr=rodada+1, ram_data=captured, ram_we=1 for exactly this cycle → NEXT_ROUND.
- NEXT_ROUND: rodada++, i=0 → SHOW_ADDR.
- WIN, LOSE: hold. iniciar → INIT; RAM contents are kept, so new items overwrite.
- jogada_valida outside PLAY_WAIT/NEW_WAIT is ignored, not queued. iniciar outside IDLE/WIN/LOSE is ignored.
- i and rodada are 4-bit. rodada+1 never wraps because NEW_WRITE is unreachable at rodada==LAST_ROUND≤15.
- Address 0 content is the preloaded first item; the game never writes address 0.

## Timing
- Reset: state IDLE, all outputs 0 (ram_addr 0, ram_we 0, ram_data 0, leds 0, rodada 0, db_estado 0), timer cleared.
- Reset mid-operation, including during NEW_WRITE: returns to IDLE next edge. ram_we is low in the cycle after reset is sampled.
- Playback per item: 1 + SHOW_CYCLES + GAP_CYCLES cycles. Round r playback: (r+1)·(1+SHOW_CYCLES+GAP_CYCLES) cycles.
- Player check latency: jogada_valida edge → PLAY_CMP decision 2 cycles later; acertou/errou assert the following cycle.
- jogada_valida arriving in PLAY_READ or PLAY_CMP is dropped.
- Timer width: enough for max(SHOW_CYCLES, GAP_CYCLES). It loads on state entry and finishes on the exact count.

## Structure
- Package memgame_pkg: state encoding constants (4-bit, values above), ADDR_W=4, DATA_W=4.
- Sub-module memgame_timer: down-counter with load, enable, done. It is parameterised by width and instantiated once. The state machine selects the SHOW or GAP count on load.
- The controller keeps the state register, i/rodada counters, capture register, and registered RAM-side outputs.

## Test plan
- Reset then iniciar, RAM[0]=2, SHOW_CYCLES=4, GAP_CYCLES=2 → leds=2 for 4 cycles, 0 for 2, then db_estado=5.
- Round 0, jogada=2 → NEW_WAIT. jogada=1 → one-cycle ram_we with ram_addr=1, ram_data=1, then rodada=1 and playback 2,1.
- Round 1, inputs 2 then 4 (expected 1) → errou=1, db_estado=C. iniciar → rodada=0, playback restarts.
- LAST_ROUND=1, correct 2,1 in round 1 → acertou=1 with no write; jogada_valida in WIN is ignored.
- jogada_valida during SHOW_ON, and during PLAY_READ → no state change, no capture.
- reset asserted in NEW_WRITE → ram_we=0 and IDLE next cycle, all outputs 0.

Source files
------------

// File: rtl/memgame_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memgame_pkg
// Purpose  : Shared definitions for the memory-challenge sequencing controller:
//            RAM geometry, the controller state encoding (also exported on the
//            debug port) and a small state-classification helper.
// Revision : 1.0 - initial release
// ============================================================================
package memgame_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 4;

    // Encodings are visible on db_estado and must stay stable.
    typedef enum logic [3:0] {
        ST_IDLE       = 4'h0,
        ST_INIT       = 4'h1,
        ST_SHOW_ADDR  = 4'h2,
        ST_SHOW_ON    = 4'h3,
        ST_SHOW_GAP   = 4'h4,
        ST_PLAY_WAIT  = 4'h5,
        ST_PLAY_READ  = 4'h6,
        ST_PLAY_CMP   = 4'h7,
        ST_NEW_WAIT   = 4'h8,
        ST_NEW_WRITE  = 4'h9,
        ST_NEXT_ROUND = 4'hA,
        ST_WIN        = 4'hB,
        ST_LOSE       = 4'hC
    } state_e;

    // True for the three states that make up sequence playback.
    function automatic logic is_show_state(input state_e s);
        return (s == ST_SHOW_ADDR) || (s == ST_SHOW_ON) || (s == ST_SHOW_GAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/memgame_timer.sv
`default_nettype none
// ============================================================================
// Module   : memgame_timer
// Purpose  : Loadable down-counter used to time LED on/off phases.
//            A load of N-1 followed by enabled cycles gives done_o high in
//            exactly the N-th cycle after the load edge.
// Ports    : clk        - clock, rising edge
//            reset      - synchronous active-high reset (clears count)
//            load_i     - load load_val_i this edge (has priority over en_i)
//            load_val_i - value to load
//            en_i       - decrement while non-zero
//            done_o     - count has reached zero
// Revision : 1.0 - initial release
// ============================================================================
module memgame_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/memory_sequence_controller.sv
`default_nettype none
// ============================================================================
// Module   : memory_sequence_controller
// Purpose  : Round sequencer for the memory-challenge game. Plays the stored
//            sequence from the 16x4 synchronous RAM on the LEDs, checks each
//            player entry against RAM, then appends one player-chosen item.
// Ports    : clk, reset           - clock / synchronous active-high reset
//            iniciar              - start pulse (IDLE, WIN, LOSE only)
//            jogada_valida,jogada - player entry strobe and value
//            ram_q                - RAM read data (one cycle after address)
//            ram_addr/we/data     - registered RAM controls
//            leds, mostrando      - playback display and playback flag
//            rodada               - current round index
//            acertou, errou       - WIN / LOSE indication
//            db_estado            - raw state encoding for debug
// Revision : 1.0 - initial release
// ============================================================================
module memory_sequence_controller
    import memgame_pkg::*;
#(
    parameter int SHOW_CYCLES = 1000,
    parameter int GAP_CYCLES  = 250,
    parameter int LAST_ROUND  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada_valida,
    input  logic [DATA_W-1:0] jogada,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_data,
    output logic [DATA_W-1:0] leds,
    output logic              mostrando,
    output logic [3:0]        rodada,
    output logic              acertou,
    output logic              errou,
    output logic [3:0]        db_estado
);

    // Timer sized for the longer of the two phases; loads hold N-1.
    localparam int unsigned c_max_cycles = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
    localparam int unsigned c_tw         = (c_max_cycles > 2) ? $clog2(c_max_cycles) : 1;
    localparam logic [c_tw-1:0] c_show_load = c_tw'(SHOW_CYCLES - 1);
    localparam logic [c_tw-1:0] c_gap_load  = c_tw'(GAP_CYCLES - 1);
    localparam logic [3:0]      c_last      = 4'(LAST_ROUND);

    state_e            state_q, state_d;
    logic [3:0]        i_q, i_d;
    logic [3:0]        rodada_q, rodada_d;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] ram_data_q, ram_data_d;

    logic              tmr_load;
    logic [c_tw-1:0]   tmr_load_val;
    logic              tmr_en;
    logic              tmr_done;

    memgame_timer #(
        .WIDTH (c_tw)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .en_i       (tmr_en),
        .done_o     (tmr_done)
    );

    // ------------------------------------------------------------------
    // Next-state, counters and timer control
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        rodada_d     = rodada_q;
        cap_d        = cap_q;
        tmr_load     = 1'b0;
        tmr_load_val = c_show_load;

        unique case (state_q)
            ST_IDLE: begin
                if (iniciar) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                rodada_d = 4'd0;
                i_d      = 4'd0;
                state_d  = ST_SHOW_ADDR;
            end
            ST_SHOW_ADDR: begin
                // RAM data for item i appears during SHOW_ON.
                tmr_load     = 1'b1;
                tmr_load_val = c_show_load;
                state_d      = ST_SHOW_ON;
            end
            ST_SHOW_ON: begin
                if (tmr_done) begin
                    tmr_load     = 1'b1;
                    tmr_load_val = c_gap_load;
                    state_d      = ST_SHOW_GAP;
                end
            end
            ST_SHOW_GAP: begin
                if (tmr_done) begin
                    if (i_q < rodada_q) begin
                        i_d     = i_q + 4'd1;
                        state_d = ST_SHOW_ADDR;
                    end else begin
                        i_d     = 4'd0;
                        state_d = ST_PLAY_WAIT;
                    end
                end
            end
            ST_PLAY_WAIT: begin
                if (jogada_valida) begin
                    cap_d   = jogada;
                    state_d = ST_PLAY_READ;
                end
            end
            ST_PLAY_READ: begin
                state_d = ST_PLAY_CMP;
            end
            ST_PLAY_CMP: begin
                if (cap_q != ram_q) begin
                    state_d = ST_LOSE;
                end else if (i_q < rodada_q) begin
                    i_d     = i_q + 4'd1;
                    state_d = ST_PLAY_WAIT;
                end else if (rodada_q == c_last) begin
                    state_d = ST_WIN;
                end else begin
                    state_d = ST_NEW_WAIT;
                end
            end
            ST_NEW_WAIT: begin
                if (jogada_valida) begin
                    cap_d   = jogada;
                    state_d = ST_NEW_WRITE;
                end
            end
            ST_NEW_WRITE: begin
                state_d = ST_NEXT_ROUND;
            end
            ST_NEXT_ROUND: begin
                rodada_d = rodada_q + 4'd1;
                i_d      = 4'd0;
                state_d  = ST_SHOW_ADDR;
            end
            ST_WIN, ST_LOSE: begin
                if (iniciar) begin
                    state_d = ST_INIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign tmr_en = (state_q == ST_SHOW_ON) || (state_q == ST_SHOW_GAP);

    // ------------------------------------------------------------------
    // RAM-side controls are computed from the upcoming state so that the
    // registered outputs are already valid during the state that owns them.
    // ------------------------------------------------------------------
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_data_d = ram_data_q;
        ram_we_d   = 1'b0;

        if (state_d == ST_SHOW_ADDR) begin
            ram_addr_d = i_d;
        end

        if ((state_q == ST_PLAY_WAIT) && (state_d == ST_PLAY_READ)) begin
            ram_addr_d = i_q;
        end

        // rodada+1 cannot wrap: NEW_WRITE is unreachable at LAST_ROUND.
        if (state_d == ST_NEW_WRITE) begin
            ram_addr_d = rodada_q + 4'd1;
            ram_data_d = cap_d;
            ram_we_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            i_q        <= '0;
            rodada_q   <= '0;
            cap_q      <= '0;
            ram_addr_q <= '0;
            ram_we_q   <= 1'b0;
            ram_data_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            rodada_q   <= rodada_d;
            cap_q      <= cap_d;
            ram_addr_q <= ram_addr_d;
            ram_we_q   <= ram_we_d;
            ram_data_q <= ram_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ram_addr  = ram_addr_q;
    assign ram_we    = ram_we_q;
    assign ram_data  = ram_data_q;
    assign leds      = (state_q == ST_SHOW_ON) ? ram_q : '0;
    assign mostrando = is_show_state(state_q);
    assign rodada    = rodada_q;
    assign acertou   = (state_q == ST_WIN);
    assign errou     = (state_q == ST_LOSE);
    assign db_estado = state_q;

endmodule
`default_nettype wire
